// File: rtl/fetch_sequencer_if.sv
// Harness/decode-side bundle for the fetch sequencer: launch, flow-control requests,
// and the fetch address and status it reports back.
interface fetch_sequencer_if #(
  parameter int unsigned A = 16
);
  logic         start_i;
  logic [1:0]   prog_sel_i;
  logic         stall_i;
  logic         branch_en_i;
  logic         branch_rel_i;
  logic [A-1:0] branch_target_i;
  logic         halt_i;
  logic [A-1:0] inst_address_o;
  logic         running_o;
  logic         done_o;
  logic [15:0]  cycle_count_o;

  modport master (
    output start_i, prog_sel_i, stall_i, branch_en_i, branch_rel_i, branch_target_i, halt_i,
    input  inst_address_o, running_o, done_o, cycle_count_o
  );

  modport slave (
    input  start_i, prog_sel_i, stall_i, branch_en_i, branch_rel_i, branch_target_i, halt_i,
    output inst_address_o, running_o, done_o, cycle_count_o
  );
endinterface

// File: rtl/fetch_sequencer.sv
// Program counter and fetch controller: launches one of four programs, applies
// halt/stall/branch requests, and counts cycles spent running.
module fetch_sequencer #(
  parameter int unsigned  A     = 16,
  parameter logic [A-1:0] PROG0 = A'(16'h0000),
  parameter logic [A-1:0] PROG1 = A'(16'h0100),
  parameter logic [A-1:0] PROG2 = A'(16'h0200),
  parameter logic [A-1:0] PROG3 = A'(16'h0300)
) (
  input  logic              clk,
  input  logic              rst,
  fetch_sequencer_if.slave  bus
);

  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  state_e         state_q, state_d;
  logic [A-1:0]   pc_q, pc_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic           running_q, running_d;
  logic           done_q, done_d;
  logic [A-1:0]   entry;
  logic           launch;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; Start only matters outside RUN
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: if (bus.start_i) state_d = ST_RUN;
      ST_RUN:           if (bus.halt_i)  state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    entry = PROG0;
    unique case (bus.prog_sel_i)
      2'd0: entry = PROG0;
      2'd1: entry = PROG1;
      2'd2: entry = PROG2;
      2'd3: entry = PROG3;
      default: entry = PROG0;
    endcase
  end

  assign launch = (state_q != ST_RUN) && bus.start_i;

  // Datapath and status next values: halt beats stall beats branch beats increment
  always_comb begin
    pc_d      = pc_q;
    cnt_d     = cnt_q;
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
    if (launch) begin
      pc_d  = entry;
      cnt_d = '0;
    end else if (state_q == ST_RUN) begin
      cnt_d = (cnt_q == {CW{1'b1}}) ? cnt_q : cnt_q + CW'(1);
      if (bus.halt_i || bus.stall_i) begin
        pc_d = pc_q;
      end else if (bus.branch_en_i) begin
        pc_d = bus.branch_rel_i ? pc_q + bus.branch_target_i : bus.branch_target_i;
      end else begin
        pc_d = pc_q + A'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q      <= PROG0;
      cnt_q     <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      running_q <= running_d;
      done_q    <= done_d;
    end
  end

  assign bus.inst_address_o = pc_q;
  assign bus.cycle_count_o  = cnt_q;
  assign bus.running_o      = running_q;
  assign bus.done_o         = done_q;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus randomized
// traffic checked against a behavioural model of the fetch rules.
module tb_fetch_sequencer;

  localparam int M_IDLE = 0;
  localparam int M_RUN  = 1;
  localparam int M_DONE = 2;

  logic clk;
  logic rst;
  int   n_cmp;
  int   n_fail;

  int          m_mode;
  logic [15:0] m_pc;
  int          m_cnt;

  fetch_sequencer_if #(.A(16)) bus ();

  fetch_sequencer #(.A(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic model_reset();
    m_mode = M_IDLE;
    m_pc   = 16'h0000;
    m_cnt  = 0;
  endtask

  // Applies the fetch rules for the inputs currently driven, then advances one edge
  task automatic tick();
    if (m_mode != M_RUN) begin
      if (bus.start_i) begin
        m_pc   = 16'(int'(bus.prog_sel_i) * 256);
        m_cnt  = 0;
        m_mode = M_RUN;
      end
    end else begin
      m_cnt = (m_cnt < 65535) ? m_cnt + 1 : 65535;
      if (bus.halt_i)            m_mode = M_DONE;
      else if (bus.stall_i)      m_pc = m_pc;
      else if (bus.branch_en_i)  m_pc = bus.branch_rel_i ? 16'(m_pc + bus.branch_target_i)
                                                         : bus.branch_target_i;
      else                       m_pc = 16'(m_pc + 16'd1);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.start_i = 0; bus.prog_sel_i = 0; bus.stall_i = 0; bus.branch_en_i = 0;
    bus.branch_rel_i = 0; bus.branch_target_i = 0; bus.halt_i = 0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic launch(input logic [1:0] sel);
    bus.start_i = 1; bus.prog_sel_i = sel;
    tick();
    bus.start_i = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    do_reset();
    n_cmp++;
    if (bus.inst_address_o !== 16'h0000 || bus.running_o !== 1'b0 ||
        bus.done_o !== 1'b0 || bus.cycle_count_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_state: addr=%h run=%b done=%b cnt=%h, want 0000/0/0/0000",
               bus.inst_address_o, bus.running_o, bus.done_o, bus.cycle_count_o);
    end
    launch(2'd1);
    tick(); tick();
    #3 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.inst_address_o !== 16'h0000 || bus.running_o !== 1'b0 ||
        bus.done_o !== 1'b0 || bus.cycle_count_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL reset_async: addr=%h run=%b done=%b cnt=%h, want 0000/0/0/0000",
               bus.inst_address_o, bus.running_o, bus.done_o, bus.cycle_count_o);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_sequential();
    launch(2'd1);
    n_cmp++;
    if (bus.inst_address_o !== 16'h0100 || bus.running_o !== 1'b1 || bus.cycle_count_o !== 16'd0) begin
      n_fail++;
      $display("FAIL seq_launch: addr=%h run=%b cnt=%h, want 0100/1/0000",
               bus.inst_address_o, bus.running_o, bus.cycle_count_o);
    end
    for (int i = 1; i <= 5; i++) begin
      tick();
      n_cmp++;
      if (bus.inst_address_o !== 16'(16'h0100 + i)) begin
        n_fail++;
        $display("FAIL seq_step%0d: addr=%h, want %h", i, bus.inst_address_o, 16'(16'h0100 + i));
      end
    end
    n_cmp++;
    if (bus.cycle_count_o !== 16'd5) begin
      n_fail++;
      $display("FAIL seq_count: cnt=%0d, want 5", bus.cycle_count_o);
    end
  endtask

  task automatic test_branches();
    do_reset();
    launch(2'd2);
    tick(); tick(); tick();
    n_cmp++;
    if (bus.inst_address_o !== 16'h0203) begin
      n_fail++;
      $display("FAIL br_setup: addr=%h, want 0203", bus.inst_address_o);
    end
    bus.branch_en_i = 1; bus.branch_rel_i = 0; bus.branch_target_i = 16'h0210;
    tick();
    n_cmp++;
    if (bus.inst_address_o !== 16'h0210) begin
      n_fail++;
      $display("FAIL br_abs: addr=%h, want 0210", bus.inst_address_o);
    end
    bus.branch_rel_i = 1; bus.branch_target_i = 16'hFFF0;
    tick();
    n_cmp++;
    if (bus.inst_address_o !== 16'h0200) begin
      n_fail++;
      $display("FAIL br_rel: addr=%h, want 0200", bus.inst_address_o);
    end
    bus.branch_rel_i = 0; bus.branch_target_i = 16'hFFFF;
    tick();
    bus.branch_en_i = 0;
    tick();
    n_cmp++;
    if (bus.inst_address_o !== 16'h0000 || bus.running_o !== 1'b1) begin
      n_fail++;
      $display("FAIL br_wrap: addr=%h run=%b, want 0000/1", bus.inst_address_o, bus.running_o);
    end
  endtask

  task automatic test_stall();
    do_reset();
    launch(2'd0);
    bus.branch_en_i = 1; bus.branch_rel_i = 0; bus.branch_target_i = 16'h0010;
    tick();
    bus.stall_i = 1; bus.branch_target_i = 16'h0040;
    tick(); tick(); tick();
    n_cmp++;
    if (bus.inst_address_o !== 16'h0010 || bus.cycle_count_o !== 16'd4) begin
      n_fail++;
      $display("FAIL stall_hold: addr=%h cnt=%0d, want 0010/4", bus.inst_address_o, bus.cycle_count_o);
    end
    bus.stall_i = 0;
    tick();
    bus.branch_en_i = 0;
    n_cmp++;
    if (bus.inst_address_o !== 16'h0040) begin
      n_fail++;
      $display("FAIL stall_release: addr=%h, want 0040", bus.inst_address_o);
    end
  endtask

  task automatic test_halt_relaunch();
    do_reset();
    launch(2'd1);
    repeat (7) tick();
    bus.halt_i = 1;
    tick();
    bus.halt_i = 0;
    n_cmp++;
    if (bus.done_o !== 1'b1 || bus.running_o !== 1'b0 ||
        bus.inst_address_o !== 16'h0107 || bus.cycle_count_o !== 16'd8) begin
      n_fail++;
      $display("FAIL halt: done=%b run=%b addr=%h cnt=%0d, want 1/0/0107/8",
               bus.done_o, bus.running_o, bus.inst_address_o, bus.cycle_count_o);
    end
    tick(); tick();
    n_cmp++;
    if (bus.inst_address_o !== 16'h0107 || bus.cycle_count_o !== 16'd8 || bus.done_o !== 1'b1) begin
      n_fail++;
      $display("FAIL done_hold: addr=%h cnt=%0d done=%b, want 0107/8/1",
               bus.inst_address_o, bus.cycle_count_o, bus.done_o);
    end
    bus.start_i = 1; bus.prog_sel_i = 2'd3;
    tick();
    n_cmp++;
    if (bus.inst_address_o !== 16'h0300 || bus.cycle_count_o !== 16'd0 ||
        bus.running_o !== 1'b1 || bus.done_o !== 1'b0) begin
      n_fail++;
      $display("FAIL relaunch: addr=%h cnt=%0d run=%b done=%b, want 0300/0/1/0",
               bus.inst_address_o, bus.cycle_count_o, bus.running_o, bus.done_o);
    end
    tick();
    bus.start_i = 0;
    n_cmp++;
    if (bus.inst_address_o !== 16'h0301 || bus.cycle_count_o !== 16'd1) begin
      n_fail++;
      $display("FAIL start_in_run: addr=%h cnt=%0d, want 0301/1", bus.inst_address_o, bus.cycle_count_o);
    end
    bus.halt_i = 1; bus.stall_i = 1; bus.branch_en_i = 1; bus.branch_target_i = 16'h0055;
    tick();
    idle_inputs();
    n_cmp++;
    if (bus.done_o !== 1'b1 || bus.inst_address_o !== 16'h0301 || bus.cycle_count_o !== 16'd2) begin
      n_fail++;
      $display("FAIL halt_priority: done=%b addr=%h cnt=%0d, want 1/0301/2",
               bus.done_o, bus.inst_address_o, bus.cycle_count_o);
    end
  endtask

  task automatic test_reset_midrun();
    do_reset();
    launch(2'd3);
    repeat (5) tick();
    n_cmp++;
    if (bus.inst_address_o !== 16'h0305) begin
      n_fail++;
      $display("FAIL midrun_setup: addr=%h, want 0305", bus.inst_address_o);
    end
    #2 rst = 1'b1;
    #1;
    n_cmp++;
    if (bus.inst_address_o !== 16'h0000 || bus.running_o !== 1'b0 ||
        bus.done_o !== 1'b0 || bus.cycle_count_o !== 16'h0000) begin
      n_fail++;
      $display("FAIL midrun_reset: addr=%h run=%b done=%b cnt=%h, want 0000/0/0/0000",
               bus.inst_address_o, bus.running_o, bus.done_o, bus.cycle_count_o);
    end
    model_reset();
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      bus.start_i         = ($urandom_range(0, 3) == 0);
      bus.prog_sel_i      = 2'($urandom_range(0, 3));
      bus.stall_i         = ($urandom_range(0, 3) == 0);
      bus.branch_en_i     = ($urandom_range(0, 3) == 0);
      bus.branch_rel_i    = 1'($urandom_range(0, 1));
      bus.branch_target_i = 16'($urandom);
      bus.halt_i          = ($urandom_range(0, 19) == 0);
      tick();
      n_cmp++;
      if (bus.inst_address_o !== m_pc || bus.cycle_count_o !== 16'(m_cnt) ||
          bus.running_o !== (m_mode == M_RUN) || bus.done_o !== (m_mode == M_DONE)) begin
        n_fail++;
        $display("FAIL random[%0d]: addr=%h cnt=%0d run=%b done=%b, want %h/%0d/%b/%b", i,
                 bus.inst_address_o, bus.cycle_count_o, bus.running_o, bus.done_o,
                 m_pc, m_cnt, (m_mode == M_RUN), (m_mode == M_DONE));
      end
    end
    idle_inputs();
  endtask

  task automatic test_saturation();
    do_reset();
    launch(2'd0);
    repeat (70000) tick();
    n_cmp++;
    if (bus.cycle_count_o !== 16'hFFFF || bus.cycle_count_o !== 16'(m_cnt)) begin
      n_fail++;
      $display("FAIL saturation: cnt=%h, want FFFF", bus.cycle_count_o);
    end
    n_cmp++;
    if (bus.inst_address_o !== m_pc || bus.running_o !== 1'b1) begin
      n_fail++;
      $display("FAIL sat_pc: addr=%h run=%b, want %h/1", bus.inst_address_o, bus.running_o, m_pc);
    end
  endtask

  initial begin
    n_cmp  = 0;
    n_fail = 0;
    rst    = 1'b1;
    idle_inputs();
    model_reset();
    test_reset();
    test_sequential();
    test_branches();
    test_stall();
    test_halt_relaunch();
    test_reset_midrun();
    test_random();
    test_saturation();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
